alu_arbiter: RTL and testbench

- Shares one combinational 64-bit ALU (add/sub/and/orr/pass-B-flag) between NUM_REQ requesters.
- Round-robin grant: each requester gets one operation issued per grant.
- ALU output is captured into a one-entry response buffer, with a valid/ready handshake toward the consumer.
- Sits between the decode/execute requesters and the shared ALU instance in the datapath.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter_rr_arbiter.sv | 32 +++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op codes, default data width and
// the response-buffer state encoding.
package alu_pkg;

  localparam int OP_W       = 3;
  localparam int DATA_W_DEF = 64;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_AND   = 3'b010;
  localparam logic [OP_W-1:0] OP_ORR   = 3'b011;
  localparam logic [OP_W-1:0] OP_PASSB = 3'b100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // Codes above pass-B are unassigned.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_PASSB;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around the arbiter.
// slave = arbiter side, master = surrounding datapath / consumer side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;

  logic [2:0]                alu_op;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin picker: first set request searching upward from ptr_i+1,
// wrapping modulo NUM_REQ. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters,
// with a one-entry response buffer. Optional illegal-op trap: ALU_ARB_OPCHECK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  buf_state_e        state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               can_issue;
  logic               grant;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [DATA_W-1:0]  cap_res;
  logic               cap_zero;

  // A full buffer can still accept a new op when it is drained in the same cycle.
  assign can_issue = (state_q == ST_EMPTY) || bus.rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (bus.req_valid),
    .en_i      (can_issue && !reset),
    .ptr_i     (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign grant         = |gnt;
  assign bus.req_ready = gnt;

  // One-hot mux; all-zero grant yields all-zero ALU inputs.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op = bus.req_op[OP_W*i +: OP_W];
        sel_a  = bus.req_a[DATA_W*i +: DATA_W];
        sel_b  = bus.req_b[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic illegal;
  logic err_q, err_d;

  assign illegal     = grant && !op_legal(sel_op);
  assign bus.alu_op  = illegal ? OP_ADD : sel_op;
  assign bus.alu_a   = illegal ? '0 : sel_a;
  assign bus.alu_b   = illegal ? '0 : sel_b;
  assign cap_res     = illegal ? '0 : bus.alu_result;
  assign cap_zero    = illegal ? 1'b1 : bus.alu_zero;
  assign err_d       = grant ? illegal : err_q;
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign bus.alu_op  = sel_op;
  assign bus.alu_a   = sel_a;
  assign bus.alu_b   = sel_b;
  assign cap_res     = bus.alu_result;
  assign cap_zero    = bus.alu_zero;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (grant) begin
      state_d = ST_FULL;
      last_d  = gnt_idx;
      id_d    = gnt_idx;
      res_d   = cap_res;
      zero_d  = cap_zero;
    end else if (state_q == ST_FULL && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.rsp_valid  = (state_q == ST_FULL);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses queued at issue time,
// popped and compared by an independent monitor on each response handshake.
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;

  typedef struct packed {
    logic [0:0]  id;
    logic [63:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Shared ALU stand-in
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_result = (bus.alu_b == '0) ? '0 : '1;
      default: bus.alu_result = '0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d result %h expected no response", bus.rsp_id, bus.rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",     64'(bus.rsp_id),  64'(e.id));
        chk("rsp_result", bus.rsp_result,   e.res);
        chk("rsp_zero",   64'(bus.rsp_zero), 64'(e.zero));
        chk("rsp_err",    64'(bus.rsp_err),  64'(e.err));
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    bus.req_valid[i]          = v;
    bus.req_op[3*i +: 3]      = op;
    bus.req_a[DATA_W*i +: 64] = a;
    bus.req_b[DATA_W*i +: 64] = b;
  endtask

  // Checks grant and ALU drive at the negedge; queues the expected response.
  task automatic check_cycle(input int g, input logic [2:0] eop, input logic [63:0] ea,
                             input logic [63:0] eb, input logic [63:0] eres,
                             input logic ez, input logic eerr);
    exp_t e;
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("alu_op",    64'(bus.alu_op),    (g < 0) ? 64'd0 : 64'(eop));
    chk("alu_a",     bus.alu_a,          (g < 0) ? 64'd0 : ea);
    chk("alu_b",     bus.alu_b,          (g < 0) ? 64'd0 : eb);
    if (g >= 0) begin
      e.id   = 1'(g);
      e.res  = eres;
      e.zero = ez;
      e.err  = eerr;
      sb.push_back(e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    set_req(0, 1'b1, 3'b000, 64'd1, 64'd1);

    // Reset: no grant, nothing driven to the ALU, buffer empty
    check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
    chk("reset_rsp_valid",  64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_result", bus.rsp_result,     64'd0);
    next_cycle();
    next_cycle();

    // Single add from requester 0
    reset = 1'b0;
    set_req(0, 1'b1, 3'b000, 64'd5, 64'd7);
    check_cycle(0, 3'b000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
    chk("empty_before_grant", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);
    check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
    chk("latency_valid", 64'(bus.rsp_valid), 64'd1);
    next_cycle();
    check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
    chk("idle_valid", 64'(bus.rsp_valid), 64'd0);
    next_cycle();

    // Both valid: last grant was 0, so order is 1,0,1,0
    set_req(0, 1'b1, 3'b001, 64'd9,    64'd9);
    set_req(1, 1'b1, 3'b010, 64'hF0,   64'h0F);
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) check_cycle(1, 3'b010, 64'hF0, 64'h0F, 64'd0, 1'b1, 1'b0);
      else            check_cycle(0, 3'b001, 64'd9,  64'd9,  64'd0, 1'b1, 1'b0);
      next_cycle();
    end

    // Backpressure: buffer holds requester 0's response, req1 must wait
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);
    set_req(1, 1'b1, 3'b000, 64'd1, 64'd2);
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
      chk("hold_valid",  64'(bus.rsp_valid), 64'd1);
      chk("hold_id",     64'(bus.rsp_id),    64'd0);
      chk("hold_result", bus.rsp_result,     64'd0);
      chk("hold_zero",   64'(bus.rsp_zero),  64'd1);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    check_cycle(1, 3'b000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
    next_cycle();

    // Pass-B flag
    set_req(1, 1'b1, 3'b100, 64'h55, 64'd0);
    check_cycle(1, 3'b100, 64'h55, 64'd0, 64'd0, 1'b1, 1'b0);
    next_cycle();
    set_req(1, 1'b1, 3'b100, 64'h55, 64'd3);
    check_cycle(1, 3'b100, 64'h55, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    next_cycle();

    // Reset while full with both pending
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'b000, 64'd3, 64'd4);
    set_req(1, 1'b1, 3'b011, 64'd1, 64'd2);
    check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
    chk("full_before_reset", 64'(bus.rsp_valid), 64'd1);
    next_cycle();
    reset = 1'b1;
    check_cycle(-1, 3'b000, 0, 0, 0, 0, 0);
    sb.delete();
    next_cycle();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    check_cycle(0, 3'b000, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0);
    chk("post_reset_valid", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    check_cycle(1, 3'b011, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
    next_cycle();
    set_req(1, 1'b0, 3'b000, 64'd0, 64'd0);

    // Illegal op 110 from requester 0 (last grant was 1)
    set_req(0, 1'b1, 3'b110, 64'd8, 64'd9);
    if (OPCHECK) check_cycle(0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
    else         check_cycle(0, 3'b110, 64'd8, 64'd9, 64'd0, 1'b1, 1'b0);
    next_cycle();
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);

    for (int c = 0; c < 20 && sb.size() != 0; c++) next_cycle();
    next_cycle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
